// File: rtl/uart_fifo_param.sv
// uart_fifo_param
//   Parametrised synchronous FIFO that buffers words between the UART
//   shift logic and the host side. Reads are show-ahead: the head word is
//   always visible on r_data while the FIFO is non-empty.
//
//   Optional feature macro: UART_FIFO_ERR_FLAGS_EN
//     defined   -> sticky overflow/underflow flags with clr_err
//     undefined -> overflow/underflow tied low, clr_err ignored
//
// Parameters
//   ADDR_WIDTH  pointer width, depth = 2**ADDR_WIDTH
//   DATA_BITS   word width
//   AF_LEVEL    almost_full  when count >= AF_LEVEL (1..depth)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL (0..depth-1)
//
// Ports
//   clk           rising-edge clock
//   Reset         asynchronous active-high reset
//   flush         synchronous clear of pointers/count, overrides wr/rd
//   wr, w_data    write request and data
//   rd            pop request
//   clr_err       clear sticky error flags
//   r_data        head word (valid while empty = 0)
//   full, empty, almost_full, almost_empty, count   status from count reg
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
module uart_fifo_param #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_BITS  = 8,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_BITS-1:0]  w_data,
  input  logic                  clr_err,
  output logic [DATA_BITS-1:0]  r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_ok, rd_ok;

  // Acceptance is gated by the registered status, so a wr+rd on a full
  // FIFO pops only and a wr+rd on an empty FIFO pushes only (no bypass).
  assign wr_ok = wr && !full  && !flush;
  assign rd_ok = rd && !empty && !flush;

  // Storage array carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign r_data       = mem[rd_ptr];
  assign count        = cnt;
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

`ifdef UART_FIFO_ERR_FLAGS_EN
  // A rejected request sets its flag; setting beats a same-cycle clear.
  // During flush wr/rd are ignored, so they cannot raise an error.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !flush)       overflow <= 1'b1;
      else if (clr_err)               overflow <= 1'b0;
      if (rd && empty && !flush)      underflow <= 1'b1;
      else if (clr_err)               underflow <= 1'b0;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
// Randomised + directed bench for uart_fifo_param (depth 8, AF 6, AE 2).
// Reference model: a byte queue plus two sticky bits.
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       Reset, flush, wr, rd, clr_err;
  logic [7:0] w_data, r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  uart_fifo_param #(.ADDR_WIDTH(3), .DATA_BITS(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .Reset(Reset), .flush(flush), .wr(wr), .rd(rd),
    .w_data(w_data), .clr_err(clr_err), .r_data(r_data), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] q[$];
  bit m_ovf = 0, m_udf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), (n == 0));
    chk("full",  32'(full),  (n == 8));
    chk("almost_full",  32'(almost_full),  (n >= 6));
    chk("almost_empty", 32'(almost_empty), (n <= 2));
    if (n > 0) chk("r_data", 32'(r_data), 32'(q[0]));
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
`else
    chk("overflow",  32'(overflow),  0);
    chk("underflow", 32'(underflow), 0);
`endif
  endtask

  // One clock with the given inputs; model follows the FIFO rules directly.
  task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d);
    bit was_full, was_empty;
    wr = w; rd = r; flush = f; clr_err = c; w_data = d;
    @(posedge clk);
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if (f) q.delete();
    else begin
      if (r && !was_empty) void'(q.pop_front());
      if (w && !was_full)  q.push_back(d);
    end
    if (!f && w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
    if (!f && r && was_empty) m_udf = 1; else if (c) m_udf = 0;
    #1;
    check_all();
    wr = 0; rd = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    Reset = 1; flush = 0; wr = 0; rd = 0; clr_err = 0; w_data = 0;
    #2;
    check_all();
    @(negedge clk); Reset = 0;

    // fill and drain
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);

    // thresholds
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 8'(8'h20 + i));
    step(0, 1, 0, 0, 8'h00);
    while (q.size() > 0) step(0, 1, 0, 0, 8'h00);

    // overflow with simultaneous wr+rd, then clear
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    step(1, 1, 0, 0, 8'hAA);
    step(0, 0, 0, 1, 8'h00);
    while (q.size() > 0) step(0, 1, 0, 0, 8'h00);

    // underflow with simultaneous wr+rd on empty
    step(1, 1, 0, 0, 8'h55);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);

    // wrap-around at count 3
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'hE0 + i));
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 8'(i));
      step(0, 1, 0, 0, 8'h00);
    end

    // flush with concurrent write
    while (q.size() < 5) step(1, 0, 0, 0, 8'h33);
    while (q.size() > 5) step(0, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h77);

    // asynchronous reset between edges
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h44);
    #2 Reset = 1;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    check_all();
    @(negedge clk); Reset = 0;

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
           8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
